// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in in clk cycles, with stuck-input timeout.
// Optional glitch filter after the synchronizer is enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 65535,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             ovf,
  output logic             stuck,
  output logic             stuck_lvl
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT < 1 || longint'(TIMEOUT) > ((64'd1 << CNT_W) - 1) || FILTER_LEN < 1) begin : g_param_check
    $error("pwm_capture: TIMEOUT must be 1..2^CNT_W-1 and FILTER_LEN at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_s_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_quiet;
  logic             r_sat;

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_cnt_inc;

  // NOTE: every flop uses <= so all registers sample the pre-edge values;
  // with = the second synchronizer stage would collapse into the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [FW-1:0] r_filt_cnt;
  logic          r_filt;

  // Output follows the synchronized input only after FILTER_LEN stable cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_cnt <= '0;
      r_filt     <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
      r_filt_cnt <= '0;
      r_filt     <= r_sync2;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_s = r_filt;
`else
  assign w_s = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s_d <= 1'b0;
    else        r_s_d <= w_s;
  end

  assign w_rise    = w_s & ~r_s_d;
  assign w_fall    = ~w_s & r_s_d;
  assign w_edge    = w_rise | w_fall;
  assign w_cnt_sat = (r_cnt == CNT_MAX);
  assign w_cnt_inc = w_cnt_sat ? r_cnt : r_cnt + 1'b1;

  // The counter holds cycles since the last rising edge of s, counting that edge cycle as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_high     <= '0;
      r_quiet    <= '0;
      r_sat      <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      ovf        <= 1'b0;
      stuck      <= 1'b0;
      stuck_lvl  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!cap_en) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_quiet   <= '0;
        r_sat     <= 1'b0;
        stuck     <= 1'b0;
        stuck_lvl <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            // IDLE is only left on a fresh enable, so this is the 0->1 clear point.
            ovf     <= 1'b0;
            r_state <= WAIT_RISE;
          end

          WAIT_RISE: begin
            if (w_edge) begin
              stuck     <= 1'b0;
              stuck_lvl <= 1'b0;
            end
            if (w_rise) begin
              r_cnt   <= CNT_ONE;
              r_sat   <= 1'b0;
              r_quiet <= '0;
              r_state <= MEAS_HIGH;
            end
          end

          MEAS_HIGH, MEAS_LOW: begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_sat) r_sat <= 1'b1;

            if (r_state == MEAS_HIGH && w_fall) begin
              r_high  <= r_cnt;
              r_quiet <= '0;
              r_state <= MEAS_LOW;
            end else if (r_state == MEAS_LOW && w_rise) begin
              period_out <= r_cnt;
              high_out   <= r_high;
              meas_valid <= 1'b1;
              if (r_sat) ovf <= 1'b1;
              r_cnt      <= CNT_ONE;
              r_sat      <= 1'b0;
              r_quiet    <= '0;
              r_state    <= MEAS_HIGH;
            end else if (r_quiet == QUIET_LAST) begin
              stuck     <= 1'b1;
              stuck_lvl <= w_s;
              r_cnt     <= '0;
              r_sat     <= 1'b0;
              r_quiet   <= '0;
              r_state   <= WAIT_RISE;
            end else begin
              r_quiet <= r_quiet + 1'b1;
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: segment-list stimulus scored against a waveform-level model.
// Honours PWM_CAP_FILTER_EN in the model so the same bench covers both builds.
module tb_pwm_capture;

  localparam int CNT_W      = 8;
  localparam int TIMEOUT    = 200;
  localparam int FILTER_LEN = 4;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             cap_en = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             ovf;
  logic             stuck;
  logic             stuck_lvl;

  pwm_capture #(
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .FILTER_LEN(FILTER_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_en    (cap_en),
    .pwm_in    (pwm_in),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .ovf       (ovf),
    .stuck     (stuck),
    .stuck_lvl (stuck_lvl)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lvl;
    int len;
  } seg_t;

  typedef struct {
    int period;
    int high;
  } res_t;

  seg_t cur_segs[$];
  res_t got_q[$];
  int   stamp_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      got_q.push_back('{int'(period_out), int'(high_out)});
      stamp_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected results from the waveform: merge equal runs (and sub-filter glitches),
  // then report H+L / H at every rising edge that closes a full high+low pair.
  task automatic model(input seg_t s[$], output res_t r[$], output bit o);
    seg_t m[$];
    int   st;
    int   hi;
    int   p;
    bit   absorb;
    r.delete();
    o = 1'b0;
    foreach (s[i]) begin
      absorb = (m.size() > 0) && (s[i].lvl == m[m.size()-1].lvl);
`ifdef PWM_CAP_FILTER_EN
      absorb = absorb || ((m.size() > 0) && (s[i].len < FILTER_LEN));
`endif
      if (absorb) m[m.size()-1].len += s[i].len;
      else        m.push_back(s[i]);
    end
    st = 0;
    hi = 0;
    for (int i = 1; i < m.size(); i++) begin
      if (m[i].lvl) begin
        if (st == 2) begin
          p = hi + m[i-1].len;
          if (p > CMAX) o = 1'b1;
          r.push_back('{(p > CMAX) ? CMAX : p, hi});
        end
        st = 1;
      end else if (st == 1) begin
        hi = m[i-1].len;
        st = 2;
      end
      if (m[i].len > TIMEOUT) st = 0;
    end
  endtask

  task automatic drive_seg(input bit lvl, input int len);
    pwm_in = lvl;
    cur_segs.push_back('{lvl, len});
    repeat (len) @(negedge clk);
  endtask

  task automatic begin_phase(input bit lvl);
    @(negedge clk);
    cap_en = 1'b0;
    pwm_in = lvl;
    repeat (12) @(negedge clk);
    cur_segs.delete();
    got_q.delete();
    stamp_q.delete();
    cap_en = 1'b1;
  endtask

  task automatic end_phase(input string name);
    res_t exp_q[$];
    bit   exp_ovf;
    int   n;
    cap_en = 1'b0;
    repeat (2) @(negedge clk);
    model(cur_segs, exp_q, exp_ovf);
    check({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_period%0d", name, i), got_q[i].period, exp_q[i].period);
      check($sformatf("%s_high%0d", name, i), got_q[i].high, exp_q[i].high);
    end
    check({name, "_ovf"}, ovf, exp_ovf);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_period"}, period_out, 0);
    check({name, "_high"}, high_out, 0);
    check({name, "_valid"}, meas_valid, 0);
    check({name, "_ovf"}, ovf, 0);
    check({name, "_stuck"}, stuck, 0);
    check({name, "_stuck_lvl"}, stuck_lvl, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Steady 30/70 pattern: results every 100 cycles.
    begin_phase(1'b0);
    drive_seg(1'b0, 20);
    for (int k = 0; k < 5; k++) begin
      drive_seg(1'b1, 30);
      drive_seg(1'b0, 70);
    end
    drive_seg(1'b1, 20);
    end_phase("steady");
    for (int i = 1; i < stamp_q.size(); i++)
      check($sformatf("steady_gap%0d", i), stamp_q[i] - stamp_q[i-1], 100);

    // Enable while high: the first fall is ignored.
    begin_phase(1'b1);
    drive_seg(1'b1, 20);
    drive_seg(1'b0, 70);
    for (int k = 0; k < 2; k++) begin
      drive_seg(1'b1, 30);
      drive_seg(1'b0, 70);
    end
    drive_seg(1'b1, 20);
    end_phase("midpulse");

    // Stuck high, then recovery.
    begin_phase(1'b0);
    drive_seg(1'b0, 20);
    drive_seg(1'b1, 30);
    drive_seg(1'b0, 70);
    drive_seg(1'b1, 190);
    check("stuck_hi_early", stuck, 0);
    drive_seg(1'b1, 20);
    check("stuck_hi", stuck, 1);
    check("stuck_hi_lvl", stuck_lvl, 1);
    check("stuck_hi_no_valid", got_q.size(), 1);
    drive_seg(1'b0, 10);
    check("stuck_hi_clear", stuck, 0);
    drive_seg(1'b0, 60);
    drive_seg(1'b1, 30);
    drive_seg(1'b0, 70);
    drive_seg(1'b1, 20);
    end_phase("stuck_hi");

    // Stuck low, then recovery.
    begin_phase(1'b0);
    drive_seg(1'b0, 20);
    drive_seg(1'b1, 30);
    drive_seg(1'b0, 210);
    check("stuck_lo", stuck, 1);
    check("stuck_lo_lvl", stuck_lvl, 0);
    drive_seg(1'b1, 30);
    check("stuck_lo_clear", stuck, 0);
    drive_seg(1'b0, 70);
    drive_seg(1'b1, 20);
    end_phase("stuck_lo");

    // Timeout boundary: a 200-cycle run survives, a 201-cycle run times out.
    begin_phase(1'b0);
    drive_seg(1'b0, 20);
    drive_seg(1'b1, 200);
    drive_seg(1'b0, 50);
    drive_seg(1'b1, 201);
    drive_seg(1'b0, 50);
    drive_seg(1'b1, 30);
    drive_seg(1'b0, 50);
    drive_seg(1'b1, 20);
    end_phase("tmo_edge");

    // Saturation: 300-cycle period in an 8-bit counter.
    begin_phase(1'b0);
    drive_seg(1'b0, 20);
    for (int k = 0; k < 3; k++) begin
      drive_seg(1'b1, 150);
      drive_seg(1'b0, 150);
    end
    drive_seg(1'b1, 20);
    end_phase("sat");

    // 250-cycle period fits; ovf cleared by re-enable.
    begin_phase(1'b0);
    drive_seg(1'b0, 20);
    check("ovf_cleared", ovf, 0);
    for (int k = 0; k < 3; k++) begin
      drive_seg(1'b1, 125);
      drive_seg(1'b0, 125);
    end
    drive_seg(1'b1, 20);
    end_phase("p250");

    // Disable mid-period: no further results, outputs hold.
    begin_phase(1'b0);
    drive_seg(1'b0, 20);
    drive_seg(1'b1, 30);
    drive_seg(1'b0, 70);
    drive_seg(1'b1, 30);
    drive_seg(1'b0, 40);
    end_phase("dis");
    for (int k = 0; k < 2; k++) begin
      pwm_in = 1'b1;
      repeat (30) @(negedge clk);
      pwm_in = 1'b0;
      repeat (70) @(negedge clk);
    end
    check("dis_no_valid", got_q.size(), 1);
    check("dis_hold_period", period_out, 100);
    check("dis_hold_high", high_out, 30);

    // Reset mid-period.
    begin_phase(1'b0);
    drive_seg(1'b0, 20);
    drive_seg(1'b1, 30);
    drive_seg(1'b0, 70);
    drive_seg(1'b1, 30);
    drive_seg(1'b0, 40);
    check("rst_pre_count", got_q.size(), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    cap_en = 1'b0;
    rst_n  = 1'b1;

    // 2-cycle low glitch inside a 30-cycle high pulse.
    begin_phase(1'b0);
    drive_seg(1'b0, 20);
    for (int k = 0; k < 2; k++) begin
      drive_seg(1'b1, 14);
      drive_seg(1'b0, 2);
      drive_seg(1'b1, 14);
      drive_seg(1'b0, 70);
    end
    drive_seg(1'b1, 20);
    end_phase("glitch");

    // Random waveforms, occasionally long enough to time out or saturate.
    for (int ph = 0; ph < 3; ph++) begin
      begin_phase(1'b0);
      drive_seg(1'b0, 20);
      for (int k = 0; k < 40; k++)
        drive_seg(k % 2 == 0, ($urandom_range(0, 7) == 0) ? $urandom_range(190, 215)
                                                         : $urandom_range(5, 160));
      drive_seg(1'b1, 20);
      end_phase($sformatf("rnd%0d", ph));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming PWM waveform and reports its period and high time in clock cycles. This is the receive-side counterpart of the PWM generator.
- Used for loopback self-test of the generator output and for measuring external PWM sources.
- Results appear in registers readable by the peripheral register block, plus a one-cycle valid strobe.

Parameters:
- CNT_W, 16, width of the measurement counters and result registers.
- TIMEOUT, 65535, number of cycles without an edge before the input is declared stuck. Must be at most 2^CNT_W-1.
- FILTER_LEN, 4, stability length in cycles for the glitch filter. Used only when PWM_CAP_FILTER_EN is defined.

Ports:
- clk  input  1  peripheral clock.
- rst_n  input  1  asynchronous, active-low reset.
- cap_en  input  1  capture enable. Low forces IDLE.
- pwm_in  input  1  PWM signal under measurement, asynchronous to clk.
- period_out  output  CNT_W  last measured period in clk cycles.
- high_out  output  CNT_W  last measured high time in clk cycles.
- meas_valid  output  1  one-cycle pulse when period_out and high_out update.
- ovf  output  1  sticky flag: a measurement saturated. Cleared when cap_en goes from 0 to 1.
- stuck  output  1  no edge seen within TIMEOUT cycles.
- stuck_lvl  output  1  synchronized level of pwm_in while stuck is 1.

Behaviour:
- Reset: period_out=0, high_out=0, meas_valid=0, ovf=0, stuck=0, stuck_lvl=0. State is IDLE. The synchronizer flops and counters are cleared.
- Synchronizer: pwm_in passes through 2 flops, giving signal s.
- Edge detection: compares s with its value one cycle earlier.
- Latency from a pin edge to the edge being detected is 3 clk cycles. The same fixed latency applies to both edges, so measured widths are unaffected.
- Measurement rule: if s is high for H cycles and then low for L cycles, the next rising edge produces period_out=H+L and high_out=H.
- State IDLE:
  - Counters are held at 0; outputs hold their last values.
  - When cap_en=1, go to WAIT_RISE.
- State WAIT_RISE:
  - Any falling edge is ignored, so capture can start mid-pulse.
  - On a rising edge, start the counter and go to MEAS_HIGH.
- State MEAS_HIGH:
  - The counter increments every cycle.
  - On a falling edge, latch the high count internally and go to MEAS_LOW.
- State MEAS_LOW:
  - The counter keeps incrementing.
  - On a rising edge:
    - load period_out and high_out from the counts;
    - pulse meas_valid for 1 cycle;
    - restart the counter at 1;
    - go to MEAS_HIGH.
  - Consecutive periods are measured with no gap between them.
- Saturation:
  - The counters saturate at 2^CNT_W-1 and never wrap.
  - A completed measurement that saturated reports the saturated value and sets ovf.
- Timeout:
  - In MEAS_HIGH or MEAS_LOW, if no edge occurs for TIMEOUT cycles, set stuck=1 and stuck_lvl=s. This signals 0% or 100% duty.
  - meas_valid is not pulsed, and the state goes to WAIT_RISE.
  - stuck clears on the next detected edge of s.
- cap_en deasserted in any state:
  - Next cycle the state is IDLE and any partial measurement is discarded.
  - meas_valid stays 0, and stuck is cleared.
- Simultaneous events: a cycle-1 edge combined with cap_en falling means disable wins.
- rst_n asserted mid-measurement: everything immediately returns to reset values; no partial result is output.

Optional Feature:
- Macro PWM_CAP_FILTER_EN.
- Defined:
  - A glitch filter sits after the synchronizer. s changes only after the synchronized input has held the new level for FILTER_LEN consecutive cycles.
  - Pulses shorter than FILTER_LEN cycles are removed.
  - Total edge latency becomes 3+FILTER_LEN cycles.
- Not defined: s is the raw synchronizer output, and FILTER_LEN is ignored.

Test Plan:
- Steady pattern: cap_en=1, pwm_in high 30 cycles and low 70, repeated. Required: meas_valid every 100 cycles, period_out=100, high_out=30, ovf=0.
- Enable mid-pulse: enable while pwm_in is high. Required: the first falling edge is ignored, and the first valid result is a full period (100/30).
- Stuck input: TIMEOUT=200, pwm_in held high. Required: stuck=1 and stuck_lvl=1 after 200 cycles with no meas_valid. After the input resumes toggling, stuck clears and a correct period is reported.
- Saturation: CNT_W=8, low time 300 cycles, TIMEOUT=255. Required: stuck asserts. Separately, with TIMEOUT unchanged and a 250-cycle period, period_out=250 and ovf=0.
- Disable and reset: deassert cap_en halfway through a period. Required: no meas_valid and outputs hold. Assert rst_n mid-period. Required: all outputs 0.
- Glitch filter (macro defined, FILTER_LEN=4): insert a 2-cycle low glitch inside a 30-cycle high pulse. Required: high_out=30 and period_out=100. With the macro undefined, the same stimulus yields a shortened high_out.
